// File: rtl/mem_map_pkg.sv
// Address map, status-bit layout and shared widths for the CPU memory responder.
package mem_map_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] MMIO_BASE_DEFAULT = 8'hF0;

  localparam logic [ADDR_W-1:0] ADDR_GPIO_OUT  = 8'hF0;
  localparam logic [ADDR_W-1:0] ADDR_GPIO_IN   = 8'hF1;
  localparam logic [ADDR_W-1:0] ADDR_TIMER     = 8'hF2;
  localparam logic [ADDR_W-1:0] ADDR_TX_DATA   = 8'hF3;
  localparam logic [ADDR_W-1:0] ADDR_TX_STATUS = 8'hF4;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 3;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus the TX byte stream, as seen by the responder.
interface mem_io_responder_if;
  import mem_map_pkg::*;

  logic [ADDR_W-1:0] AddressBus;
  logic [DATA_W-1:0] WriteDataBus;
  logic              MemwriteEnable;
  logic [DATA_W-1:0] ReadDataBus;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  AddressBus, WriteDataBus, MemwriteEnable, tx_ready,
    output ReadDataBus, tx_data, tx_valid
  );

  modport master (
    output AddressBus, WriteDataBus, MemwriteEnable, tx_ready,
    input  ReadDataBus, tx_data, tx_valid
  );
endinterface

// File: rtl/tx_fifo.sv
// Small power-of-two TX FIFO; a push into a full FIFO is still taken when a pop frees a slot.
module tx_fifo
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head_c,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push_c, do_pop_c;
  logic [CNT_W-1:0]  count_nxt_c;

  always_comb begin
    do_pop_c    = pop && !empty;
    do_push_c   = push && (!full || do_pop_c);
    count_nxt_c = count;
    if (do_push_c && !do_pop_c)
      count_nxt_c = count + CNT_W'(1);
    else if (!do_push_c && do_pop_c)
      count_nxt_c = count - CNT_W'(1);
  end

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (!reset && do_push_c)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/mem_io_responder.sv
// RAM plus memory-mapped GPIO, timer and TX FIFO behind the CPU's 8-bit bus.
// Reads are combinational so a single-cycle CPU sees data in the same cycle.
module mem_io_responder
  import mem_map_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_io_responder_if.slave  bus,
  output logic [DATA_W-1:0]  gpio_out,
  input  logic [DATA_W-1:0]  gpio_in
);

  localparam int unsigned RAM_WORDS = 32'(MMIO_BASE);

  // Register offsets relative to the I/O page, so MMIO_BASE can move the page.
  localparam logic [ADDR_W-1:0] OFF_GPIO_OUT  = ADDR_GPIO_OUT  - MMIO_BASE_DEFAULT;
  localparam logic [ADDR_W-1:0] OFF_GPIO_IN   = ADDR_GPIO_IN   - MMIO_BASE_DEFAULT;
  localparam logic [ADDR_W-1:0] OFF_TIMER     = ADDR_TIMER     - MMIO_BASE_DEFAULT;
  localparam logic [ADDR_W-1:0] OFF_TX_DATA   = ADDR_TX_DATA   - MMIO_BASE_DEFAULT;
  localparam logic [ADDR_W-1:0] OFF_TX_STATUS = ADDR_TX_STATUS - MMIO_BASE_DEFAULT;

  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] gpio_in_q;
  logic [DATA_W-1:0] timer;
  logic              ovf;

  logic              is_ram_c;
  logic [ADDR_W-1:0] io_off_c;
  logic              wr_io_c;
  logic              push_c, pop_c, ovf_set_c, ovf_clr_c;
  logic [DATA_W-1:0] rd_c;

  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    is_ram_c  = (bus.AddressBus < MMIO_BASE);
    io_off_c  = bus.AddressBus - MMIO_BASE;
    wr_io_c   = bus.MemwriteEnable && !is_ram_c;
    pop_c     = bus.tx_valid && bus.tx_ready;
    push_c    = wr_io_c && (io_off_c == OFF_TX_DATA);
    ovf_set_c = push_c && fifo_full && !pop_c;
    ovf_clr_c = wr_io_c && (io_off_c == OFF_TX_STATUS) && bus.WriteDataBus[STAT_OVF];
  end

  // RAM ignores reset, so a store in the reset cycle still lands.
  always_ff @(posedge clk) begin
    if (bus.MemwriteEnable && is_ram_c)
      ram[bus.AddressBus] <= bus.WriteDataBus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out  <= '0;
      gpio_in_q <= '0;
      timer     <= '0;
      ovf       <= 1'b0;
    end else begin
      gpio_in_q <= gpio_in;
      if (wr_io_c && (io_off_c == OFF_GPIO_OUT))
        gpio_out <= bus.WriteDataBus;
      if (wr_io_c && (io_off_c == OFF_TIMER))
        timer <= bus.WriteDataBus;
      else
        timer <= timer + DATA_W'(1);
      if (ovf_set_c)
        ovf <= 1'b1;
      else if (ovf_clr_c)
        ovf <= 1'b0;
    end
  end

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push_c),
    .pop    (pop_c),
    .wdata  (bus.WriteDataBus),
    .head_c (bus.tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;

  always_comb begin
    rd_c = '0;
    if (is_ram_c) begin
      rd_c = ram[bus.AddressBus];
    end else begin
      case (io_off_c)
        OFF_GPIO_OUT: rd_c = gpio_out;
        OFF_GPIO_IN:  rd_c = gpio_in_q;
        OFF_TIMER:    rd_c = timer;
        OFF_TX_STATUS: begin
          rd_c[STAT_FULL]               = fifo_full;
          rd_c[STAT_EMPTY]              = fifo_empty;
          rd_c[STAT_OVF]                = ovf;
          rd_c[STAT_CNT_LSB +: CNT_W]   = fifo_count;
        end
        default:      rd_c = '0;
      endcase
    end
  end

  assign bus.ReadDataBus = rd_c;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed vector tables, hand sequences and random traffic against a queue-based model.
module tb_mem_io_responder;

  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wd;
    logic       we;
    logic       rdy;
    logic       rst;
    logic [7:0] gin;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;

  mem_io_responder_if bus();

  mem_io_responder #(.MMIO_BASE(8'hF0), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_ram [256];
  bit         m_known [256];
  logic [7:0] m_gpio;
  logic [7:0] m_gin_q;
  int         m_timer;
  bit         m_ovf;
  logic [7:0] m_q [$];

  vec_t vt [$];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic [7:0] addr, input logic [7:0] wd, input logic we,
                             input logic rdy, input logic rst, input logic [7:0] gin,
                             input logic chk, input logic [7:0] exp);
    vec_t r;
    r.addr = addr; r.wd = wd; r.we = we; r.rdy = rdy; r.rst = rst;
    r.gin = gin; r.chk = chk; r.exp = exp;
    return r;
  endfunction

  function automatic logic [8:0] m_read(input logic [7:0] a);
    int n;
    n = m_q.size();
    if (a < 8'hF0) return {m_known[a], m_ram[a]};
    case (a)
      8'hF0:   return {1'b1, m_gpio};
      8'hF1:   return {1'b1, m_gin_q};
      8'hF2:   return {1'b1, 8'(m_timer)};
      8'hF4:   return {1'b1, 2'b00, 3'(n), m_ovf, (n == 0), (n == DEPTH)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic m_update(input vec_t t);
    bit pop, push, clr;
    int n;
    if (t.we && t.addr < 8'hF0) begin
      m_ram[t.addr]   = t.wd;
      m_known[t.addr] = 1'b1;
    end
    if (t.rst) begin
      m_gpio = 8'h00; m_gin_q = 8'h00; m_timer = 0; m_ovf = 1'b0;
      m_q.delete();
      return;
    end
    n    = m_q.size();
    pop  = (n != 0) && t.rdy;
    push = t.we && (t.addr == 8'hF3);
    clr  = t.we && (t.addr == 8'hF4) && t.wd[2];
    m_gin_q = t.gin;
    if (t.we && t.addr == 8'hF0) m_gpio = t.wd;
    if (t.we && t.addr == 8'hF2) m_timer = int'(t.wd);
    else                         m_timer = (m_timer + 1) % 256;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (n < DEPTH || pop) m_q.push_back(t.wd);
      else m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
  endtask

  // One bus cycle: drive at negedge, compare pre-edge outputs, then advance the model.
  task automatic cycle(input vec_t t);
    logic [8:0] mr;
    @(negedge clk);
    bus.AddressBus     = t.addr;
    bus.WriteDataBus   = t.wd;
    bus.MemwriteEnable = t.we;
    bus.tx_ready       = t.rdy;
    reset              = t.rst;
    gpio_in            = t.gin;
    #1;
    if (!t.rst) begin
      mr = m_read(t.addr);
      if (mr[8]) check("model_rd", bus.ReadDataBus, mr[7:0]);
      if (t.chk) check("vec_rd", bus.ReadDataBus, t.exp);
      check("gpio_out", gpio_out, m_gpio);
      check("tx_valid", 8'(bus.tx_valid), 8'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", bus.tx_data, m_q[0]);
    end
    m_update(t);
  endtask

  task automatic run_table();
    for (int i = 0; i < vt.size(); i++) cycle(vt[i]);
    vt.delete();
  endtask

  task automatic drain(input logic [7:0] exp [$]);
    logic [7:0] got [$];
    for (int i = 0; i < 8; i++) begin
      cycle(v(8'hF4, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 8'h00));
      if (bus.tx_valid) got.push_back(bus.tx_data);
    end
    check("drain_count", 8'(got.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check("drain_byte", (i < got.size()) ? got[i] : 8'hXX, exp[i]);
  endtask

  initial begin
    vec_t rv;
    logic [7:0] ex [$];

    for (int i = 0; i < 256; i++) begin m_ram[i] = 8'h00; m_known[i] = 1'b0; end
    m_gpio = 8'h00; m_gin_q = 8'h00; m_timer = 0; m_ovf = 1'b0;
    reset = 1'b1; gpio_in = 8'h00;
    bus.AddressBus = 8'h00; bus.WriteDataBus = 8'h00;
    bus.MemwriteEnable = 1'b0; bus.tx_ready = 1'b0;

    // Reset, RAM, timer, GPIO, unmapped space, FIFO fill with overflow
    vt.push_back(v(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00));
    vt.push_back(v(8'h00, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00));
    vt.push_back(v(8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    vt.push_back(v(8'h10, 8'hA5, 1, 0, 0, 8'h00, 0, 8'h00));
    vt.push_back(v(8'h10, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA5));
    vt.push_back(v(8'hEF, 8'h3C, 1, 0, 0, 8'h00, 0, 8'h00));
    vt.push_back(v(8'hEF, 8'h00, 0, 0, 0, 8'h00, 1, 8'h3C));
    vt.push_back(v(8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h05));
    vt.push_back(v(8'hF0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    vt.push_back(v(8'hF2, 8'hFE, 1, 0, 0, 8'h00, 0, 8'h00));
    vt.push_back(v(8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'hFE));
    vt.push_back(v(8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'hFF));
    vt.push_back(v(8'hF2, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00));
    vt.push_back(v(8'hF0, 8'h5A, 1, 0, 0, 8'h00, 0, 8'h00));
    vt.push_back(v(8'hF0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h5A));
    vt.push_back(v(8'hF1, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF1, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hC3));
    vt.push_back(v(8'hF1, 8'h77, 1, 0, 0, 8'hC3, 1, 8'hC3));
    vt.push_back(v(8'hF1, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hC3));
    vt.push_back(v(8'hF7, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hFF, 8'hAA, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF3, 8'h11, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF3, 8'h22, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF3, 8'h33, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF3, 8'h44, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF3, 8'h55, 1, 0, 0, 8'hC3, 1, 8'h00));
    vt.push_back(v(8'hF4, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h25));
    run_table();

    ex = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain(ex);

    // Overflow clear, then push+pop on a full FIFO
    vt.push_back(v(8'hF4, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h06));
    vt.push_back(v(8'hF4, 8'h04, 1, 0, 0, 8'hC3, 1, 8'h06));
    vt.push_back(v(8'hF4, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h02));
    vt.push_back(v(8'hF3, 8'hA1, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hA2, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hA3, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hA4, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'h66, 1, 1, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF4, 8'h00, 0, 0, 0, 8'hC3, 1, 8'h21));
    run_table();

    ex = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
    drain(ex);

    // Push into empty FIFO with sink ready: valid for exactly one cycle
    cycle(v(8'hF3, 8'h99, 1, 1, 0, 8'hC3, 0, 8'h00));
    check("empty_push_n", 8'(bus.tx_valid), 8'h00);
    cycle(v(8'hF4, 8'h00, 0, 1, 0, 8'hC3, 0, 8'h00));
    check("empty_push_n1_valid", 8'(bus.tx_valid), 8'h01);
    check("empty_push_n1_data", bus.tx_data, 8'h99);
    cycle(v(8'hF4, 8'h00, 0, 1, 0, 8'hC3, 0, 8'h00));
    check("empty_push_n2", 8'(bus.tx_valid), 8'h00);

    // Reset mid-drain with bytes queued; RAM write in the reset cycle sticks
    vt.push_back(v(8'h20, 8'hBE, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hB1, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hB2, 1, 0, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'hF3, 8'hB3, 1, 1, 0, 8'hC3, 0, 8'h00));
    vt.push_back(v(8'h30, 8'hD7, 1, 1, 1, 8'hC3, 0, 8'h00));
    run_table();
    cycle(v(8'hF4, 8'h00, 0, 1, 0, 8'hC3, 1, 8'h02));
    check("rst_tx_valid", 8'(bus.tx_valid), 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);
    vt.push_back(v(8'h20, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hBE));
    vt.push_back(v(8'h30, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hD7));
    vt.push_back(v(8'h10, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hA5));
    vt.push_back(v(8'hF1, 8'h00, 0, 0, 0, 8'hC3, 1, 8'hC3));
    run_table();

    // Random traffic checked only against the model
    for (int i = 0; i < 3000; i++) begin
      rv.addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15))
                                            : 8'($urandom_range(240, 255));
      rv.wd   = 8'($urandom);
      rv.we   = 1'($urandom_range(0, 1));
      rv.rdy  = 1'($urandom_range(0, 1));
      rv.rst  = ($urandom_range(0, 299) == 0);
      rv.gin  = 8'($urandom);
      rv.chk  = 1'b0;
      rv.exp  = 8'h00;
      cycle(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's 8-bit memory bus. Decodes AddressBus into 240 bytes of RAM plus a memory-mapped I/O page: GPIO out/in, a free-running timer, and a 4-entry transmit FIFO drained over a valid/ready stream. Sits at the CPU top level, wired directly to AddressBus, WriteDataBus, ReadDataBus and MemwriteEnable. Reads are combinational so a single-cycle CPU sees data in the same cycle.

## Interface
Parameters:
- MMIO_BASE, 8'hF0, first I/O address; RAM occupies 0x00..MMIO_BASE-1.
- FIFO_DEPTH, 4, TX FIFO entries; legal values 2 or 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- AddressBus  in  8  byte address from CPU.
- WriteDataBus  in  8  store data from CPU.
- MemwriteEnable  in  1  store strobe; write commits at the next rising edge.
- ReadDataBus  out  8  combinational read data for AddressBus.
- gpio_out  out  8  GPIO_OUT register value.
- gpio_in  in  8  external input; registered once before being readable.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  sink accepts; pop when tx_valid && tx_ready.

## Operation
- RAM, 0x00..MMIO_BASE-1: read combinational; write on edge when MemwriteEnable. Reset does not alter contents; simulation initial contents are 0x00.
- 0xF0 GPIO_OUT: R/W; reset 0x00.
- 0xF1 GPIO_IN: RO; returns gpio_in registered last edge; reset 0x00; writes ignored.
- 0xF2 TIMER: +1 every cycle, 0xFF wraps to 0x00; a write loads WriteDataBus, and the increment is suppressed that cycle. Reset 0x00.
- 0xF3 TX_DATA: a write pushes WriteDataBus. Reads return 0x00.
- 0xF4 TX_STATUS:
  - bit0 full; bit1 empty; bit2 overflow (sticky); bits[5:3] count; bits[7:6] 0.
  - A write with bit2=1 clears overflow; other bits are ignored.
- 0xF5..0xFF: read 0x00; writes ignored.
- Push rules:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs the same cycle.
  - Otherwise the data is dropped and overflow is set.
  - If an overflow set and a clear occur in the same cycle, the set wins.
- Simultaneous push and pop:
  - Non-empty FIFO: both happen; count unchanged.
  - Empty FIFO: push only; no pop because tx_valid is low.
- Pointers wrap modulo FIFO_DEPTH. Count has a 3-bit width.

## Timing
- ReadDataBus reflects pre-edge state. A read of an address written in the same cycle returns the old value.
- A TX_DATA write in cycle N gives tx_valid=1 and tx_data=byte in cycle N+1.
- A pop at edge N advances tx_data at N+1. tx_data is don't-care when tx_valid=0.
- Reset values:
  - ReadDataBus follows decode: 0x00 for I/O addresses; RAM contents for RAM addresses.
  - gpio_out=0x00, tx_valid=0.
  - FIFO emptied; pointers and count = 0; overflow=0; timer=0x00; GPIO_IN register=0x00.
- Reset mid-operation: queued bytes are discarded. A write asserted in the reset cycle is ignored for registers and FIFO, but still commits to RAM.

## Structure
- Package mem_map_pkg: MMIO_BASE default; address constants ADDR_GPIO_OUT, ADDR_GPIO_IN, ADDR_TIMER, ADDR_TX_DATA, ADDR_TX_STATUS; status bit indices STAT_FULL, STAT_EMPTY, STAT_OVF, STAT_CNT_LSB.
- Sub-module tx_fifo: push/pop/full/empty/count, parameterised by depth.
- The top contains the address decode, RAM array, registers, timer and read mux.

## Test plan
- RAM: write 0xA5 to 0x10, read 0x10 next cycle -> 0xA5. Write 0x3C to 0xEF -> read 0x3C; 0xF0 unaffected.
- Timer: release reset, read 0xF2 after 5 cycles -> 0x05. Write 0xFE, then read on the following two cycles -> 0xFE, 0xFF. One cycle later -> 0x00.
- FIFO fill with tx_ready=0: push 0x11, 0x22, 0x33, 0x44, then 0x55. TX_STATUS -> full=1, ovf=1, count=4. Raise tx_ready -> bytes 0x11..0x44 drained in order; 0x55 never appears.
- Full FIFO with push and pop in the same cycle: push accepted, count stays 4, overflow stays 0.
- Clear overflow: write 0x04 to 0xF4 -> bit2 reads 0. Push to empty FIFO with tx_ready=1 -> tx_valid high exactly one cycle, starting N+1.
- Reset mid-drain with 3 bytes queued -> tx_valid=0 next cycle, status empty=1, count=0, gpio_out=0x00; previously written RAM values preserved.
